macrocell_cfg_loader: RTL
=========================

// Module: macrocell_cfg_loader
// PURPOSE
//  Upstream configuration stage for the macrocell array. Receives the fuse bitstream serially,
//  checks it, and drives every macrocell's *_mux config inputs from a double-buffered store.
//  Macrocells never see a partially loaded or corrupt configuration.
// PARAMETERS
//  NUM_MC   16     number of macrocells configured
//  CFG_W    21     config bits per macrocell (16 single muxes + oe_mux[0:2] + gclk_mux[0:1])
//  SYNC     8'hA5  sync pattern that precedes the payload
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  start      in   1              begin a load; honoured only in IDLE, DONE or ERR
//  bit_in     in   1              serial data, MSB first
//  bit_valid  in   1              bit_in is sampled only when high; gaps of any length allowed
//  busy       out  1              high in SYNC, SHIFT and COMMIT
//  done       out  1              one-cycle pulse: a load committed
//  err        out  1              sticky parity failure; cleared by the next accepted start
//  cfg_valid  out  1              high once any load has committed
//  cfg_out    out  NUM_MC*CFG_W   active config; macrocell m uses bits [m*CFG_W +: CFG_W]
// BEHAVIOUR
//  Reset: state=IDLE; busy=done=err=cfg_valid=0; cfg_out, shadow store and counters = 0.
//   Reset mid-load abandons the load and also clears the active cfg_out.
//  Word layout, bit CFG_W-1 down to 0: pt1,pt2,pt3,pt4,pt5,gclr,pt4_func,pt5_func,xor_a,
//   xor_b,xor_inv,d,dfast,storage,fb,o (bits 20..5), oe_mux[0:2] (bits 4..2), gclk_mux[0:1] (1..0).
//  Frame: SYNC byte, then NUM_MC records in order mc0 first. Each record is CFG_W data bits
//   followed by 1 parity bit. Even parity: XOR of all CFG_W+1 bits == 0.
//  FSM:
//   IDLE: start -> SYNC (err<=0, mc_cnt<=0).
//   SYNC: 8-bit sliding window on valid bits; window==SYNC -> SHIFT. Sync may occur at any
//    alignment; there is no timeout.
//   SHIFT: bit_cnt counts 0..CFG_W on valid bits. Data bits shift into the word register; the
//    running parity is updated on every bit. At the parity bit:
//    - parity ok: write the word to shadow[mc_cnt]. If mc_cnt==NUM_MC-1 -> COMMIT,
//      else mc_cnt++ and bit_cnt<=0.
//    - parity bad: -> ERR with err<=1. Shadow store is discarded; cfg_out is unchanged.
//   COMMIT (1 cycle): cfg_out<=shadow, cfg_valid<=1, done<=1 -> DONE.
//   DONE / ERR: start -> SYNC; otherwise hold.
//  Latency: cfg_out and done change on the second rising edge after the edge that samples the
//   last parity bit (that edge enters COMMIT; the next one performs it).
//  start while busy: ignored. bit_valid low in any state: no shift, counters hold.
//  Valid bits in IDLE, DONE or ERR: ignored.
//  Simultaneous start and bit_valid in IDLE: the bit is ignored; sync hunting begins next cycle.
//  Counters never wrap: bit_cnt is 0..CFG_W, mc_cnt is 0..NUM_MC-1, sized by $clog2.
// STRUCTURE
//  Package macrocell_cfg_pkg:
//   - field index localparams (PT1_IDX..GCLK_IDX)
//   - CFG_W and the SYNC constant
//   - state encoding: IDLE, SYNC, SHIFT, COMMIT, DONE, ERR
//  Sub-module cfg_word_shifter: CFG_W-bit shift register, bit counter and running parity.
//   Outputs word, word_done and parity_ok.
//  The top level holds the FSM, mc_cnt, the shadow array and the active cfg_out register.
// TESTING
//  1 rst held 2 cycles -> all outputs 0; state IDLE.
//  2 NUM_MC=2: start; stream A5, mc0=21'h100001+p, mc1=21'h0001F+p, all bit_valid=1
//    -> done pulses once; cfg_out={21'h0001F,21'h100001}; cfg_valid=1; err=0.
//  3 Same stream with mc1 parity flipped -> err=1; done never pulses; cfg_out keeps the prior
//    load; the next start clears err and a good stream loads.
//  4 Stream preceded by 5 junk bits 10110, with random bit_valid gaps
//    -> same cfg_out as scenario 2; busy stays high throughout.
//  5 rst pulsed after mc0 has loaded -> cfg_out=0, cfg_valid=0, IDLE; later bits ignored.
//  6 start pulsed mid-SHIFT -> no effect; the load completes normally.

Source files
------------

// File: rtl/macrocell_cfg_pkg.sv
// Shared constants for the macrocell configuration loader: word layout, sync byte, FSM states.
// No logic here; latency and backpressure are defined by the modules that import it.
// Field indices give each macrocell mux select's bit position inside one CFG_W-bit word.
package macrocell_cfg_pkg;

    localparam int CFG_W = 21;
    localparam logic [7:0] SYNC_PAT = 8'hA5;

    localparam int PT1_IDX      = 20;
    localparam int PT2_IDX      = 19;
    localparam int PT3_IDX      = 18;
    localparam int PT4_IDX      = 17;
    localparam int PT5_IDX      = 16;
    localparam int GCLR_IDX     = 15;
    localparam int PT4_FUNC_IDX = 14;
    localparam int PT5_FUNC_IDX = 13;
    localparam int XOR_A_IDX    = 12;
    localparam int XOR_B_IDX    = 11;
    localparam int XOR_INV_IDX  = 10;
    localparam int D_IDX        = 9;
    localparam int DFAST_IDX    = 8;
    localparam int STORAGE_IDX  = 7;
    localparam int FB_IDX       = 6;
    localparam int O_IDX        = 5;
    localparam int OE_IDX       = 2;    // oe_mux[0:2] occupies bits 4..2
    localparam int GCLK_IDX     = 0;    // gclk_mux[0:1] occupies bits 1..0

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/cfg_word_shifter.sv
// Deserialises one CFG_W-bit record plus its even-parity bit, MSB first.
// Latency: word_done/parity_ok are combinational on the cycle the parity bit is presented.
// Backpressure: none; en low simply holds the shift register, counter and parity.
module cfg_word_shifter
    import macrocell_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CFG_W-1:0] word,
    output logic             word_done,
    output logic             parity_ok
);

    localparam int CNT_W = $clog2(CFG_W + 1);

    logic [CFG_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             parity_q, parity_d;
    logic             at_parity;

    assign at_parity = (bit_cnt_q == CNT_W'(CFG_W));
    assign word      = word_q;
    assign word_done = en && at_parity;
    assign parity_ok = ~(parity_q ^ bit_in);

    always_comb begin
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        if (clr) begin
            word_d    = '0;
            bit_cnt_d = '0;
            parity_d  = 1'b0;
        end else if (en) begin
            if (at_parity) begin
                // parity bit closes the record; the word itself is left intact for the writer
                bit_cnt_d = '0;
                parity_d  = 1'b0;
            end else begin
                word_d    = {word_q[CFG_W-2:0], bit_in};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                parity_d  = parity_q ^ bit_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
        end else begin
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
        end
    end

endmodule

// File: rtl/macrocell_cfg_loader.sv
// Loads the serial fuse bitstream into a shadow store and commits it atomically to cfg_out.
// Latency: cfg_out/done update on the 2nd rising edge after the edge sampling the last parity bit.
// Backpressure: none; bit_valid gaps stall the load, start is ignored while busy.
module macrocell_cfg_loader
    import macrocell_cfg_pkg::*;
#(
    parameter int         NUM_MC = 16,
    parameter logic [7:0] SYNC   = SYNC_PAT
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    cfg_valid,
    output logic [NUM_MC*CFG_W-1:0] cfg_out
);

    localparam int MC_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

    state_e                         state_q, state_d;
    logic [MC_W-1:0]                mc_cnt_q, mc_cnt_d;
    logic [7:0]                     win_q, win_d, win_next;
    logic [NUM_MC-1:0][CFG_W-1:0]   shadow_q, shadow_d;
    logic [NUM_MC*CFG_W-1:0]        cfg_q, cfg_d;
    logic                           cfg_valid_q, cfg_valid_d;
    logic                           err_q, err_d;
    logic                           done_q, done_d;
    logic                           busy_q, busy_d;

    logic                           start_ok;
    logic                           shift_en;
    logic [CFG_W-1:0]               word;
    logic                           word_done;
    logic                           parity_ok;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign shift_en = (state_q == ST_SHIFT) && bit_valid;
    assign win_next = {win_q[6:0], bit_in};

    cfg_word_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .en        (shift_en),
        .bit_in    (bit_in),
        .word      (word),
        .word_done (word_done),
        .parity_ok (parity_ok)
    );

    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        win_d       = win_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_SYNC;
                    err_d    = 1'b0;
                    mc_cnt_d = '0;
                    win_d    = '0;
                end
            end
            ST_SYNC: begin
                // window starts at zero and SYNC has its MSB set, so no match before 8 bits
                if (bit_valid) begin
                    win_d = win_next;
                    if (win_next == SYNC) state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (word_done) begin
                    if (parity_ok) begin
                        shadow_d[mc_cnt_q] = word;
                        if (mc_cnt_q == MC_W'(NUM_MC - 1)) state_d = ST_COMMIT;
                        else mc_cnt_d = mc_cnt_q + MC_W'(1);
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                cfg_d       = shadow_q;
                cfg_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_COMMIT);
        busy_d = (state_d == ST_SYNC) || (state_d == ST_SHIFT) || (state_d == ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mc_cnt_q    <= '0;
            win_q       <= '0;
            shadow_q    <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            win_q       <= win_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_out   = cfg_q;

endmodule
